// File: rtl/sm_clkdiv_gen.sv
// Per-state-machine fractional clock-enable generator.
// Each SM emits a registered single-cycle enable at an average rate of 1/(INT+FRAC/256).
module sm_clkdiv_gen #(
    parameter int N_SM   = 4,
    parameter int INT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_SM-1:0][INT_W+FRAC_W-1:0]      fsm_clkdiv,
    input  logic [N_SM-1:0]                        sm_en,
    input  logic [N_SM-1:0]                        clkdiv_restart,
    output logic [N_SM-1:0]                        sm_clk_en
);

    logic [N_SM-1:0] fire;
    logic [N_SM-1:0] sm_clk_en_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_SM; gi++) begin : g_sm
            logic [INT_W:0]    cnt_q;
            logic [INT_W:0]    cnt_d;
            logic [FRAC_W-1:0] acc_q;
            logic [FRAC_W-1:0] acc_d;
            logic [INT_W-1:0]  div_int;
            logic [FRAC_W-1:0] div_frac;
            logic [INT_W:0]    period;
            logic [FRAC_W:0]   sum;
            logic [INT_W:0]    carry_ext;

            assign div_int  = fsm_clkdiv[gi][FRAC_W +: INT_W];
            assign div_frac = fsm_clkdiv[gi][FRAC_W-1:0];

            // INT==0 encodes the longest period, 2**INT_W, so the counter needs one extra bit.
            assign period    = (div_int == '0) ? {1'b1, {INT_W{1'b0}}} : {1'b0, div_int};
            assign sum       = {1'b0, acc_q} + {1'b0, div_frac};
            assign carry_ext = {{INT_W{1'b0}}, sum[FRAC_W]};

            assign fire[gi] = sm_en[gi] & ~clkdiv_restart[gi] & (cnt_q == '0);

            always_comb begin
                cnt_d = cnt_q;
                acc_d = acc_q;
                if (clkdiv_restart[gi]) begin
                    cnt_d = '0;
                    acc_d = '0;
                end else if (!sm_en[gi]) begin
                    cnt_d = cnt_q;
                    acc_d = acc_q;
                end else if (cnt_q == '0) begin
                    // Divisor is sampled only here, so mid-period writes never truncate a count.
                    acc_d = sum[FRAC_W-1:0];
                    cnt_d = period - {{INT_W{1'b0}}, 1'b1} + carry_ext;
                end else begin
                    cnt_d = cnt_q - {{INT_W{1'b0}}, 1'b1};
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                    acc_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                    acc_q <= acc_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sm_clk_en_q <= '0;
        end else begin
            sm_clk_en_q <= fire;
        end
    end

    assign sm_clk_en = sm_clk_en_q;

endmodule

// File: tb/tb_sm_clkdiv_gen.sv
// Directed self-checking bench for sm_clkdiv_gen.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_sm_clkdiv_gen;

    localparam int N_SM   = 4;
    localparam int INT_W  = 16;
    localparam int FRAC_W = 8;

    logic                              clk;
    logic                              rst;
    logic [N_SM-1:0][INT_W+FRAC_W-1:0] fsm_clkdiv;
    logic [N_SM-1:0]                   sm_en;
    logic [N_SM-1:0]                   clkdiv_restart;
    logic [N_SM-1:0]                   sm_clk_en;

    int tests_run = 0;
    int tests_failed = 0;

    sm_clkdiv_gen #(
        .N_SM   (N_SM),
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fsm_clkdiv     (fsm_clkdiv),
        .sm_en          (sm_en),
        .clkdiv_restart (clkdiv_restart),
        .sm_clk_en      (sm_clk_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_div(input int idx, input logic [15:0] div_int, input logic [7:0] div_frac);
        fsm_clkdiv[idx] = {div_int, div_frac};
    endtask

    logic [31:0] mask;
    int          cnt;
    int          gap;
    bit          found;

    initial begin
        rst            = 1'b0;
        sm_en          = 4'hF;
        clkdiv_restart = 4'h0;
        for (int i = 0; i < N_SM; i++) set_div(i, 16'd1, 8'd0);

        // 1: reset holds outputs low; release gives continuous enables at INT=1
        mask = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            mask = mask | {28'd0, sm_clk_en};
        end
        check_eq("rst_hold", mask, 32'h0);
        rst = 1'b1;
        check_eq("rst_release_pre", {28'd0, sm_clk_en}, 32'h0);
        tick();
        check_eq("rst_release_1", {28'd0, sm_clk_en}, 32'hF);
        tick();
        check_eq("rst_release_2", {28'd0, sm_clk_en}, 32'hF);

        // 2: SM0 INT=3 -> one pulse every 3 cycles
        sm_en = 4'h0;
        for (int i = 0; i < N_SM; i++) set_div(i, 16'd0, 8'd0);
        set_div(0, 16'd3, 8'd0);
        clkdiv_restart = 4'hF;
        tick();
        clkdiv_restart = 4'h0;
        check_eq("restart_quiet", {28'd0, sm_clk_en}, 32'h0);
        sm_en = 4'b0001;
        mask = '0;
        cnt  = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            mask[k] = sm_clk_en[0];
            if (sm_clk_en[0]) cnt++;
        end
        check_eq("int3_pattern", mask, 32'h09249249);
        check_eq("int3_count", cnt, 32'd10);

        // 3: SM1 INT=1 FRAC=0x80 -> 1,1,0 repeating
        sm_en = 4'h0;
        set_div(1, 16'd1, 8'h80);
        clkdiv_restart = 4'b0010;
        tick();
        clkdiv_restart = 4'h0;
        sm_en = 4'b0010;
        mask = '0;
        cnt  = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (k < 30) mask[k] = sm_clk_en[1];
            if (sm_clk_en[1]) cnt++;
        end
        check_eq("frac_pattern", mask, 32'h1B6DB6DB);
        check_eq("frac_count", cnt, 32'd200);

        // 4: two SMs one cycle out of phase, realigned by a joint restart
        sm_en = 4'h0;
        set_div(0, 16'd2, 8'd0);
        set_div(1, 16'd2, 8'd0);
        clkdiv_restart = 4'b0011;
        tick();
        clkdiv_restart = 4'h0;
        sm_en = 4'b0001;
        tick();
        check_eq("phase_sm0_first", {28'd0, sm_clk_en}, 32'h1);
        sm_en = 4'b0011;
        tick();
        tick();
        tick();
        check_eq("phase_offset", {28'd0, sm_clk_en}, 32'h2);
        clkdiv_restart = 4'b0011;
        tick();
        clkdiv_restart = 4'h0;
        check_eq("align_restart", {28'd0, sm_clk_en}, 32'h0);
        mask = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            mask[k*2 +: 2] = sm_clk_en[1:0];
        end
        check_eq("align_pattern", mask, 32'h33);

        // 5: SM2 INT=0 -> 65536-cycle period, paused 100 cycles mid-count
        sm_en = 4'h0;
        set_div(2, 16'd0, 8'd0);
        clkdiv_restart = 4'b0100;
        tick();
        clkdiv_restart = 4'h0;
        sm_en = 4'b0100;
        tick();
        check_eq("int0_first", {31'd0, sm_clk_en[2]}, 32'h1);
        gap   = 0;
        found = 1'b0;
        for (int k = 1; k <= 70000 && !found; k++) begin
            tick();
            if (sm_clk_en[2]) begin
                found = 1'b1;
                gap   = k;
            end
            if (k == 1000) sm_en = 4'b0000;
            if (k == 1100) sm_en = 4'b0100;
        end
        check_eq("int0_found", {31'd0, found}, 32'h1);
        check_eq("int0_gap", gap, 32'd65636);

        // 6: SM3 INT=4 changed to 2 mid-period, then async reset mid-count
        sm_en = 4'h0;
        set_div(3, 16'd4, 8'd0);
        clkdiv_restart = 4'b1000;
        sm_en = 4'b1000;
        tick();
        clkdiv_restart = 4'h0;
        check_eq("restart_with_en", {31'd0, sm_clk_en[3]}, 32'h0);
        mask = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            mask[k] = sm_clk_en[3];
            if (k == 1) set_div(3, 16'd2, 8'd0);
        end
        check_eq("div_change", mask, 32'h151);
        tick();
        check_eq("pre_rst_pulse", {31'd0, sm_clk_en[3]}, 32'h1);
        rst = 1'b0;
        #1;
        check_eq("async_rst", {28'd0, sm_clk_en}, 32'h0);
        tick();
        tick();
        check_eq("rst_held", {28'd0, sm_clk_en}, 32'h0);
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
